// File: rtl/multicycle_mem_pc_unit.sv
// multicycle_mem_pc_unit: PC/IR/MDR owner sitting behind the multicycle control unit.
// Runs a three-state (IDLE/WAIT/DONE) handshake to a variable-latency memory and
// stalls the control unit while an access is outstanding.
module multicycle_mem_pc_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            PCWrite,
  input  logic            PCWriteCond,
  input  logic            IorD,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic            IRWrite,
  input  logic            PCSource1,
  input  logic            PCSource0,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] alu_out,
  input  logic            alu_zero,
  input  logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            stall,
  output logic            mem_err,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     ir,
  output logic [XLEN-1:0] mdr
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [XLEN-1:0] pc_reg, pc_next, addr_reg, wdata_reg, mdr_reg;
  logic [31:0]     ir_reg;
  logic            rd_reg, wr_reg, irw_reg, err_reg;
  logic            req, ld_data, timeout_hit, pc_en;

  // Next-state, handshake outputs, stall and PC source selection.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    stall       = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    req         = 1'b0;
    ld_data     = 1'b0;
    timeout_hit = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        stall    = MemRead | MemWrite;
        cnt_next = '0;
        if (MemRead | MemWrite) begin
          req        = 1'b1;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall  = 1'b1;
        mem_rd = rd_reg;
        mem_wr = wr_reg;
        if (mem_ready) begin
          ld_data    = rd_reg;
          state_next = ST_DONE;
        end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
          // Abort: nothing is loaded, the sticky error is raised instead.
          timeout_hit = 1'b1;
          state_next  = ST_DONE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      ST_DONE: begin
        // Strobes may still be high here; returning to IDLE without
        // looking at them is what prevents a duplicate request.
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    pc_en = (PCWrite | (PCWriteCond & alu_zero)) & ~stall;
    case ({PCSource1, PCSource0})
      2'b00:   pc_next = alu_result;
      2'b01:   pc_next = alu_out;
      2'b10:   pc_next = {pc_reg[XLEN-1:28], ir_reg[25:0], 2'b00};
      default: pc_next = pc_reg;
    endcase
  end

  // State, request latch, architectural registers and sticky error.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      pc_reg    <= RESET_PC;
      ir_reg    <= '0;
      mdr_reg   <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rd_reg    <= 1'b0;
      wr_reg    <= 1'b0;
      irw_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (req) begin
        // Uses the PC as it is before any same-cycle PC write.
        addr_reg  <= IorD ? alu_out : pc_reg;
        wdata_reg <= store_data;
        rd_reg    <= MemRead & ~MemWrite;
        wr_reg    <= MemWrite;
        irw_reg   <= IRWrite;
      end
      if (ld_data) begin
        mdr_reg <= mem_rdata;
        if (irw_reg) ir_reg <= mem_rdata[31:0];
      end
      if (timeout_hit) err_reg <= 1'b1;
      if (pc_en) pc_reg <= pc_next;
    end
  end

  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign mem_err   = err_reg;
  assign pc        = pc_reg;
  assign ir        = ir_reg;
  assign mdr       = mdr_reg;

endmodule
